// File: rtl/vsim_trace_player.sv
// Replay source for the 2-bit flag trace channel: fetches (stamp, v) records from the trace
// source, buffers them and emits each once the cycle counter reaches its stamp.
// Optional late-emission accounting is built with `define VSIM_TRACE_PLAYER_LATE_CHECK_EN.

// Trace source with the DPI-C call signatures; a captured trace is loaded into 'trace'.
package vsim_trace_player_pkg;
  typedef struct {
    int ret;
    int stamp;
    int v;
  } trace_ent_t;

  trace_ent_t trace[$];
  int         rd_idx       = 0;
  int         fetch_calls  = 0;
  int         rewind_calls = 0;

  function automatic int dpi_traceFetch(output int stamp, output int v);
    int ret;
    stamp = 0;
    v     = 0;
    fetch_calls++;
    if (rd_idx >= trace.size()) return -1;
    stamp = trace[rd_idx].stamp;
    v     = trace[rd_idx].v;
    ret   = trace[rd_idx].ret;
    rd_idx++;
    return ret;
  endfunction

  function automatic void dpi_traceRewind();
    rd_idx = 0;
    rewind_calls++;
  endfunction
endpackage

module vsim_trace_player #(
  parameter int DEPTH   = 4,
  parameter int STAMP_W = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  output logic        flag__ENA,
  input  logic        flag__RDY,
  output logic [1:0]  flag_v,
  output logic        done,
  output logic [31:0] replay_count,
  output logic [15:0] late_count
);
  import vsim_trace_player_pkg::*;

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [1:0]         v;
  } rec_t;

  rec_t               mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q, occ;
  logic [STAMP_W-1:0] cyc_q;
  logic               eot_q, done_q, rst_q;
  logic [31:0]        replay_q;
  rec_t               head;
  logic               empty, full, head_due, pop;

  // Pointers carry one extra wrap bit so occupancy is a plain difference.
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign empty    = (occ == '0);
  assign full     = (occ == (AW+1)'(DEPTH));
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_due = en && !empty && (cyc_q >= head.stamp);
  assign pop      = head_due && flag__RDY;

  assign flag__ENA    = pop;
  assign flag_v       = empty ? 2'b00 : head.v;
  assign done         = done_q;
  assign replay_count = replay_q;

  // Fetch side: full is sampled before this edge's pop, so a freed slot is refilled next cycle.
  always_ff @(posedge CLK) begin : fetch_p
    int f_ret, f_stamp, f_v;
    rst_q <= nRST;
    if (nRST) begin
      if (!rst_q) dpi_traceRewind();
      wr_ptr_q <= '0;
      eot_q    <= 1'b0;
    end else if (en && !eot_q && !full) begin
      f_ret = dpi_traceFetch(f_stamp, f_v);
      if (f_ret == 1) begin
        mem_q[wr_ptr_q[AW-1:0]] <= '{stamp: STAMP_W'(unsigned'(f_stamp)), v: f_v[1:0]};
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end else if (f_ret < 0) begin
        eot_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      rd_ptr_q <= '0;
      cyc_q    <= '0;
      done_q   <= 1'b0;
      replay_q <= '0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        replay_q <= replay_q + 32'd1;
      end
      if (en) cyc_q <= cyc_q + 1'b1;
      // No push can occur once eot is set, so empty-after-pop is occ == pop.
      if (eot_q && (occ == (AW+1)'(pop))) done_q <= 1'b1;
    end
  end

`ifdef VSIM_TRACE_PLAYER_LATE_CHECK_EN
  logic [15:0] late_q;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      late_q <= '0;
    end else if (pop && (cyc_q > head.stamp)) begin
      if (late_q != 16'hFFFF) late_q <= late_q + 16'd1;
      $display("trace late: stamp=%0d cyc=%0d", head.stamp, cyc_q);
    end
  end

  assign late_count = late_q;
`else
  assign late_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vsim_trace_player.sv
// Bench for vsim_trace_player: directed test-plan scenarios plus randomized traces,
// each cycle checked against a queue-based model of the replay rules.
module tb_vsim_trace_player;
  import vsim_trace_player_pkg::*;

  localparam int DEPTH = 4;
  localparam bit LATE_EN =
`ifdef VSIM_TRACE_PLAYER_LATE_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic        CLK = 1'b1;
  logic        nRST = 1'b1;
  logic        en = 1'b0;
  logic        flag__RDY = 1'b0;
  logic        flag__ENA;
  logic [1:0]  flag_v;
  logic        done;
  logic [31:0] replay_count;
  logic [15:0] late_count;

  vsim_trace_player #(.DEPTH(DEPTH), .STAMP_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flag__ENA(flag__ENA), .flag__RDY(flag__RDY),
    .flag_v(flag_v), .done(done), .replay_count(replay_count), .late_count(late_count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of pending records plus counters, advanced once per clock.
  typedef struct {
    int unsigned stamp;
    logic [1:0]  v;
  } mrec_t;

  mrec_t       mq[$];
  int          m_idx = 0, m_fetches = 0, m_rewinds = 0, m_replay = 0, m_late = 0;
  int unsigned m_cyc = 0;
  bit          m_eot = 0, m_done = 0, m_prev_rst = 0;
  bit          exp_ena;
  logic [1:0]  exp_v;

  function automatic int exp_late();
    return LATE_EN ? m_late : 0;
  endfunction

  task automatic add(input int ret, input int stamp, input int v);
    trace_ent_t te;
    te.ret = ret; te.stamp = stamp; te.v = v;
    trace.push_back(te);
  endtask

  task automatic drive(input bit rst, input bit e, input bit r);
    @(negedge CLK);
    nRST = rst; en = e; flag__RDY = r;
    #1;
    exp_ena = e && (mq.size() > 0) && (m_cyc >= mq[0].stamp) && r;
    exp_v   = (mq.size() > 0) ? mq[0].v : 2'b00;
  endtask

  task automatic advance();
    int    occ0;
    bit    eot0;
    int    tv;
    mrec_t rec;
    occ0 = mq.size();
    eot0 = m_eot;
    if (nRST) begin
      if (!m_prev_rst) begin m_idx = 0; m_rewinds++; end
      mq.delete();
      m_cyc = 0; m_eot = 0; m_done = 0; m_replay = 0; m_late = 0;
    end else begin
      if (exp_ena) begin
        if (m_cyc > mq[0].stamp && m_late < 65535) m_late++;
        void'(mq.pop_front());
        m_replay++;
      end
      if (en && !eot0 && occ0 < DEPTH) begin
        m_fetches++;
        if (m_idx >= trace.size()) m_eot = 1;
        else begin
          if (trace[m_idx].ret == 1) begin
            tv = trace[m_idx].v;
            rec.stamp = unsigned'(trace[m_idx].stamp);
            rec.v = tv[1:0];
            mq.push_back(rec);
          end else if (trace[m_idx].ret < 0) m_eot = 1;
          m_idx++;
        end
      end
      if (en) m_cyc++;
      if (eot0 && mq.size() == 0) m_done = 1;
    end
    m_prev_rst = nRST;
    @(posedge CLK);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin drive(1, 0, 0); advance(); end
  endtask

  task automatic test_reset();
    trace.delete();
    do_reset();
    drive(0, 0, 0);
    checks++;
    if (flag__ENA !== 1'b0 || flag_v !== 2'd0 || done !== 1'b0 || replay_count !== 0 || late_count !== 0) begin
      errors++;
      $display("FAIL reset_outputs got ena=%b v=%0d done=%b rc=%0d lc=%0d want all 0",
               flag__ENA, flag_v, done, replay_count, late_count);
    end
    checks++;
    if (rewind_calls !== 1 || fetch_calls !== 0) begin
      errors++;
      $display("FAIL reset_dpi got rewinds=%0d fetches=%0d want 1 and 0", rewind_calls, fetch_calls);
    end
    advance();
  endtask

  task automatic test_basic();
    string sched = "";
    trace.delete();
    add(1, 3, 1); add(1, 5, 2); add(1, 5, 3); add(-1, 0, 0);
    do_reset();
    for (int t = 0; t < 10; t++) begin
      drive(0, 1, 1);
      if (flag__ENA === 1'b1) sched = {sched, $sformatf("%0d:%0d ", m_cyc, flag_v)};
      checks++;
      if (flag__ENA !== exp_ena || flag_v !== exp_v || done !== m_done ||
          replay_count !== m_replay || late_count !== exp_late()) begin
        errors++;
        $display("FAIL basic_cycle t=%0d got ena=%b v=%0d done=%b rc=%0d lc=%0d want ena=%b v=%0d done=%b rc=%0d lc=%0d",
                 t, flag__ENA, flag_v, done, replay_count, late_count, exp_ena, exp_v, m_done, m_replay, exp_late());
      end
      advance();
    end
    checks++;
    if (sched != "3:1 5:2 6:3 " || replay_count !== 32'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL basic_schedule got '%s' rc=%0d done=%b want '3:1 5:2 6:3 ' rc=3 done=1", sched, replay_count, done);
    end
  endtask

  task automatic test_stall();
    string sched = "";
    trace.delete();
    add(1, 3, 1); add(1, 5, 2); add(1, 5, 3); add(-1, 0, 0);
    do_reset();
    for (int t = 0; t < 13; t++) begin
      drive(0, 1, !(m_cyc >= 3 && m_cyc <= 7));
      if (flag__ENA === 1'b1) sched = {sched, $sformatf("%0d:%0d ", m_cyc, flag_v)};
      checks++;
      if (flag__ENA !== exp_ena || flag_v !== exp_v || done !== m_done ||
          replay_count !== m_replay || late_count !== exp_late()) begin
        errors++;
        $display("FAIL stall_cycle t=%0d got ena=%b v=%0d done=%b rc=%0d lc=%0d want ena=%b v=%0d done=%b rc=%0d lc=%0d",
                 t, flag__ENA, flag_v, done, replay_count, late_count, exp_ena, exp_v, m_done, m_replay, exp_late());
      end
      advance();
    end
    checks++;
    if (sched != "8:1 9:2 10:3 " || late_count !== (LATE_EN ? 16'd3 : 16'd0)) begin
      errors++;
      $display("FAIL stall_schedule got '%s' lc=%0d want '8:1 9:2 10:3 ' lc=%0d", sched, late_count, LATE_EN ? 3 : 0);
    end
  endtask

  task automatic test_full();
    string got = "", want = "";
    int    f0, first = -1, last = -1, hits = 0;
    trace.delete();
    for (int i = 0; i < 10; i++) begin
      add(1, 0, (i % 3) + 1);
      want = {want, $sformatf("%0d ", (i % 3) + 1)};
    end
    add(-1, 0, 0);
    do_reset();
    f0 = fetch_calls;
    for (int t = 0; t < 22; t++) begin
      drive(0, 1, t >= 8);
      if (flag__ENA === 1'b1) begin
        got = {got, $sformatf("%0d ", flag_v)};
        if (first < 0) first = t;
        last = t; hits++;
      end
      checks++;
      if (flag__ENA !== exp_ena || flag_v !== exp_v || done !== m_done ||
          replay_count !== m_replay || late_count !== exp_late()) begin
        errors++;
        $display("FAIL full_cycle t=%0d got ena=%b v=%0d done=%b rc=%0d lc=%0d want ena=%b v=%0d done=%b rc=%0d lc=%0d",
                 t, flag__ENA, flag_v, done, replay_count, late_count, exp_ena, exp_v, m_done, m_replay, exp_late());
      end
      if (t == 7) begin
        checks++;
        if (fetch_calls - f0 !== DEPTH) begin
          errors++;
          $display("FAIL full_no_fetch got %0d fetch calls while full want %0d", fetch_calls - f0, DEPTH);
        end
      end
      advance();
    end
    checks++;
    if (got != want || hits != 10 || last - first != 9) begin
      errors++;
      $display("FAIL full_drain got '%s' hits=%0d span=%0d want '%s' hits=10 span=9", got, hits, last - first, want);
    end
  endtask

  task automatic test_en_pause();
    string sched = "";
    trace.delete();
    add(1, 10, 2); add(-1, 0, 0);
    do_reset();
    for (int t = 0; t < 20; t++) begin
      drive(0, !(t >= 4 && t < 8), 1);
      if (flag__ENA === 1'b1) sched = {sched, $sformatf("%0d:%0d ", t, flag_v)};
      checks++;
      if (flag__ENA !== exp_ena || flag_v !== exp_v || done !== m_done ||
          replay_count !== m_replay || late_count !== exp_late()) begin
        errors++;
        $display("FAIL pause_cycle t=%0d got ena=%b v=%0d done=%b rc=%0d lc=%0d want ena=%b v=%0d done=%b rc=%0d lc=%0d",
                 t, flag__ENA, flag_v, done, replay_count, late_count, exp_ena, exp_v, m_done, m_replay, exp_late());
      end
      advance();
    end
    checks++;
    if (sched != "14:2 " || replay_count !== 32'd1) begin
      errors++;
      $display("FAIL pause_schedule got '%s' rc=%0d want '14:2 ' rc=1", sched, replay_count);
    end
  endtask

  task automatic test_reset_mid();
    string got = "";
    int    r0, t = 0;
    trace.delete();
    add(1, 2, 1); add(1, 3, 2); add(1, 4, 3); add(1, 5, 1); add(1, 6, 2); add(-1, 0, 0);
    do_reset();
    while (m_replay < 2 && t < 20) begin
      drive(0, 1, 1); advance(); t++;
    end
    r0 = rewind_calls;
    do_reset();
    drive(0, 0, 0);
    checks++;
    if (flag__ENA !== 1'b0 || flag_v !== 2'd0 || done !== 1'b0 || replay_count !== 0 ||
        late_count !== 0 || rewind_calls - r0 !== 1) begin
      errors++;
      $display("FAIL midreset_state got ena=%b v=%0d done=%b rc=%0d lc=%0d rewinds=%0d want zeros and 1 rewind",
               flag__ENA, flag_v, done, replay_count, late_count, rewind_calls - r0);
    end
    advance();
    t = 0;
    while (!m_done && t < 40) begin
      drive(0, 1, 1);
      if (flag__ENA === 1'b1) got = {got, $sformatf("%0d ", flag_v)};
      checks++;
      if (flag__ENA !== exp_ena || flag_v !== exp_v || done !== m_done ||
          replay_count !== m_replay || late_count !== exp_late()) begin
        errors++;
        $display("FAIL midreset_cycle t=%0d got ena=%b v=%0d done=%b rc=%0d lc=%0d want ena=%b v=%0d done=%b rc=%0d lc=%0d",
                 t, flag__ENA, flag_v, done, replay_count, late_count, exp_ena, exp_v, m_done, m_replay, exp_late());
      end
      advance(); t++;
    end
    #1;
    checks++;
    if (got != "1 2 3 1 2 " || replay_count !== 32'd5 || done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_replay got '%s' rc=%0d done=%b want '1 2 3 1 2 ' rc=5 done=1", got, replay_count, done);
    end
  endtask

  task automatic test_wide_v();
    string sched = "";
    trace.delete();
    for (int i = 0; i < 5; i++) add(0, 0, 0);
    add(1, 0, 7); add(-1, 0, 0);
    do_reset();
    for (int t = 0; t < 10; t++) begin
      drive(0, 1, 1);
      if (flag__ENA === 1'b1) sched = {sched, $sformatf("%0d:%0d ", m_cyc, flag_v)};
      checks++;
      if (flag__ENA !== exp_ena || flag_v !== exp_v || done !== m_done ||
          replay_count !== m_replay || late_count !== exp_late()) begin
        errors++;
        $display("FAIL widev_cycle t=%0d got ena=%b v=%0d done=%b rc=%0d lc=%0d want ena=%b v=%0d done=%b rc=%0d lc=%0d",
                 t, flag__ENA, flag_v, done, replay_count, late_count, exp_ena, exp_v, m_done, m_replay, exp_late());
      end
      advance();
    end
    checks++;
    if (sched != "6:3 ") begin
      errors++;
      $display("FAIL widev_schedule got '%s' want '6:3 '", sched);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int nrec = 0, base = 0, st, t = 0;
      trace.delete();
      for (int i = 0; i < 12 + int'($urandom_range(0, 8)); i++) begin
        if ($urandom_range(0, 4) == 0) add(0, 0, 0);
        base += int'($urandom_range(0, 3));
        st = ($urandom_range(0, 7) == 0) ? base - int'($urandom_range(0, base)) : base;
        add(1, st, int'($urandom));
        nrec++;
      end
      add(-1, 0, 0);
      do_reset();
      while (!m_done && t < 400) begin
        drive(0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
        checks++;
        if (flag__ENA !== exp_ena || flag_v !== exp_v || done !== m_done ||
            replay_count !== m_replay || late_count !== exp_late()) begin
          errors++;
          $display("FAIL random_cycle it=%0d t=%0d got ena=%b v=%0d done=%b rc=%0d lc=%0d want ena=%b v=%0d done=%b rc=%0d lc=%0d",
                   it, t, flag__ENA, flag_v, done, replay_count, late_count, exp_ena, exp_v, m_done, m_replay, exp_late());
        end
        advance(); t++;
      end
      #1;
      checks++;
      if (done !== 1'b1 || replay_count !== nrec || fetch_calls !== m_fetches || rewind_calls !== m_rewinds) begin
        errors++;
        $display("FAIL random_end it=%0d got done=%b rc=%0d fetches=%0d rewinds=%0d want done=1 rc=%0d fetches=%0d rewinds=%0d",
                 it, done, replay_count, fetch_calls, rewind_calls, nrec, m_fetches, m_rewinds);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_en_pause();
    test_reset_mid();
    test_wide_v();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vsim_trace_player.md
Name: vsim_trace_player

Overview:
- Simulation-only replay source for the 2-bit flag trace channel. It is the transmitting end that feeds the flag-trace recorder.
- Pulls time-stamped records from the C side over DPI-C and buffers them in a small FIFO.
- Issues each record as an outbound flag method call (flag__ENA/flag__RDY/flag$v) once the local cycle counter reaches the record's stamp.
- Used to drive a DUT's flag input from a previously captured trace.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- STAMP_W, 32, width of the cycle counter and the record stamp.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset (synchronous, active-high)
- en  input  1  replay enable; 0 pauses fetch, counter and emission
- flag__ENA  output  1  method enable, asserted only while flag__RDY=1
- flag__RDY  input  1  downstream ready
- flag$v  output  2  flag value of the FIFO head record
- done  output  1  sticky: end-of-trace seen and FIFO drained
- replay_count  output  32  count of completed transfers
- late_count  output  16  records emitted after their stamp (see Optional Feature)

Behaviour:
- Reset is nRST, synchronous, active-high; clock is CLK. While nRST=1:
  - FIFO emptied; cyc=0; eot=0; done=0; replay_count=0; late_count=0.
  - No DPI fetch calls are made.
  - dpi_traceRewind() is called exactly once, on the first reset cycle (nRST registered 0, now 1).
- Outputs are then: flag__ENA=0 and flag$v=0 while the FIFO is empty.
- DPI imports:
  - int dpi_traceFetch(output int stamp, output int v). Return 1 = record valid; 0 = none this cycle; negative = end of trace.
  - void dpi_traceRewind().
- Fetch, on each posedge with nRST=0, en=1, eot=0 and FIFO not full (occupancy sampled at the start of the cycle):
  - Call dpi_traceFetch once.
  - Return 1: push {stamp[STAMP_W-1:0], v[1:0]}; upper bits of v are discarded.
  - Return 0: no push.
  - Return <0: eot<=1; no further calls until reset.
- No fetch while full, even if a pop occurs in the same cycle (no bypass).
- Cycle counter: cyc increments by 1 on each posedge with nRST=0 and en=1. It wraps modulo 2^STAMP_W; the comparison is plain unsigned.
- Emission, combinational:
  - head_due = en & !empty & (cyc >= head.stamp)
  - flag__ENA = head_due & flag__RDY
  - flag$v = head.v when not empty, else 0
- Transfer: flag__ENA=1 at a posedge pops the head and increments replay_count. At most one pop per cycle.
- Latency: a record pushed at edge N is at the head no earlier than edge N+1 (no empty-FIFO bypass). Back-to-back records with equal or already-passed stamps emit on consecutive cycles.
- Out-of-order stamps (stamp smaller than a predecessor's) are not reordered; they emit as soon as they reach the head.
- Simultaneous push and pop on a non-full FIFO: both occur and occupancy is unchanged.
- done is registered: done<=1 when eot=1 and the FIFO is empty after this cycle's pop. It stays 1 until reset.
- en=0 mid-record: ENA drops immediately, the head is held and the counter freezes. Replay resumes with no loss when en=1.
- Reset mid-replay: buffered records are discarded and the C side is rewound; replay restarts from cyc=0.

Optional Feature:
- Macro: VSIM_TRACE_PLAYER_LATE_CHECK_EN.
- Defined:
  - On each transfer where cyc > head.stamp, late_count increments, saturating at 16'hFFFF.
  - $display prints "trace late: stamp=%0d cyc=%0d".
- Undefined: late_count is tied to 0 and no late-check logic or $display is built.

Test Plan:
- Trace records (stamp,v) = (3,1),(5,2),(5,3), then EOT; en=1, RDY=1 -> ENA pulses at cyc=3 (v=1), cyc=5 (v=2), cyc=6 (v=3); replay_count=3; done=1 one cycle after the last pop.
- Same trace with RDY=0 during cyc 3..7 -> ENA=0 throughout; at cyc 8 v=1, cyc 9 v=2, cyc 10 v=3; with LATE_CHECK_EN, late_count=3.
- DEPTH=4, 10 records all stamp 0, RDY held 0 -> occupancy stops at 4 with no DPI calls while full; after RDY=1, ten consecutive transfers in stamp order.
- en toggled 0 for 4 cycles before stamp 10 -> first ENA at absolute cycle 14, flag$v unchanged, no record lost or duplicated.
- nRST=1 for 2 cycles after 2 of 5 records have replayed -> exactly one rewind call, all outputs 0; after release the full 5-record sequence replays from the start; replay_count ends at 5.
- Record with v=7 and stamp 0, with cyc past its stamp (e.g. 0xFFFFFFFE) -> flag$v=3; record emitted on the next cycle after reaching head.
